// File: rtl/banked_register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : banked_register_file_pkg
// Description : Shared mode encodings, architectural addresses and the
//               mode/address to physical-entry banking map.
// Revision    : 1.0
// ============================================================================
package banked_register_file_pkg;

    typedef enum logic [1:0] {
        MODE_USR  = 2'b00,
        MODE_IRQ  = 2'b01,
        MODE_SVC  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    localparam logic [3:0] PC_ADDR         = 4'd15;
    localparam logic [3:0] LR_ADDR         = 4'd14;
    localparam int         NUM_PHYS_BANKED = 19;
    localparam int         NUM_PHYS_FLAT   = 15;
    localparam int         PHYS_W          = 5;

    typedef logic [PHYS_W-1:0] phys_idx_t;

    // PC has no storage; it maps to an index no entry ever matches.
    localparam phys_idx_t PHYS_NONE = 5'd31;

    // IRQ copies of R13/R14 live at 15/16, SVC copies at 17/18.
    function automatic phys_idx_t phys_map(input logic [1:0] mode,
                                           input logic [3:0] addr,
                                           input logic       banked);
        phys_idx_t idx;
        idx = phys_idx_t'(addr);
        if (addr == PC_ADDR) begin
            idx = PHYS_NONE;
        end else if ((addr >= 4'd13) && banked) begin
            case (mode_e'(mode))
                MODE_IRQ: idx = phys_idx_t'(addr) + 5'd2;
                MODE_SVC: idx = phys_idx_t'(addr) + 5'd4;
                default:  idx = phys_idx_t'(addr);
            endcase
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/banked_register_file_if.sv
`default_nettype none
// ============================================================================
// Module      : banked_register_file_if
// Description : Read/write/lock bus of the banked register file.
// Revision    : 1.0
// ============================================================================
interface banked_register_file_if #(
    parameter int DATA_W   = 32,
    parameter int RD_PORTS = 3
);
    logic [1:0]               mode;
    logic [4*RD_PORTS-1:0]    rd_addr;
    logic [DATA_W*RD_PORTS-1:0] rd_data;
    logic [RD_PORTS-1:0]      rd_busy;
    logic [DATA_W-1:0]        pc_content;
    logic                     wa_en;
    logic [3:0]               wa_addr;
    logic [DATA_W-1:0]        wa_data;
    logic                     wb_en;
    logic [3:0]               wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     link;
    logic                     lock_en;
    logic [3:0]               lock_addr;
    logic                     pc_write;
    logic [DATA_W-1:0]        pc_data;
    logic                     wr_collide;

    modport master (
        output mode, rd_addr, pc_content, wa_en, wa_addr, wa_data,
               wb_en, wb_addr, wb_data, link, lock_en, lock_addr,
        input  rd_data, rd_busy, pc_write, pc_data, wr_collide
    );

    modport slave (
        input  mode, rd_addr, pc_content, wa_en, wa_addr, wa_data,
               wb_en, wb_addr, wb_data, link, lock_en, lock_addr,
        output rd_data, rd_busy, pc_write, pc_data, wr_collide
    );
endinterface
`default_nettype wire

// File: rtl/banked_register_file_reg_lock_table.sv
`default_nettype none
// ============================================================================
// Module      : reg_lock_table
// Description : Per-physical-register load lock bits with per-port lookup.
// Revision    : 1.0
// ============================================================================
module reg_lock_table
    import banked_register_file_pkg::*;
#(
    parameter int NUM_ENTRIES = 19,
    parameter int RD_PORTS    = 3
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       i_set_en,
    input  wire phys_idx_t                  i_set_idx,
    input  wire logic                       i_clr_en,
    input  wire phys_idx_t                  i_clr_idx,
    input  wire logic [PHYS_W*RD_PORTS-1:0] i_rd_idx,
    input  wire logic [RD_PORTS-1:0]        i_rd_pc,
    output logic      [RD_PORTS-1:0]        o_busy
);

    logic [NUM_ENTRIES-1:0] r_lock;

    // Set is tested first so a same-cycle set and clear leaves the lock on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock <= '0;
        end else begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (i_set_en && (i_set_idx == phys_idx_t'(j))) begin
                    r_lock[j] <= 1'b1;
                end else if (i_clr_en && (i_clr_idx == phys_idx_t'(j))) begin
                    r_lock[j] <= 1'b0;
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < RD_PORTS; i++) begin : g_busy
            phys_idx_t w_idx;
            logic      w_locked;

            assign w_idx = i_rd_idx[PHYS_W*i +: PHYS_W];

            always_comb begin
                w_locked = 1'b0;
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    if (w_idx == phys_idx_t'(j)) begin
                        w_locked = r_lock[j];
                    end
                end
            end

            // A load landing this cycle is bypassed, so it no longer stalls.
            assign o_busy[i] = w_locked && !i_rd_pc[i] &&
                               !(i_clr_en && (i_clr_idx == w_idx));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/banked_register_file.sv
`default_nettype none
// ============================================================================
// Module      : banked_register_file
// Description : ARM-style register file, banked R13/R14, two write ports,
//               link write, write-to-read bypass and load lock scoreboard.
// Revision    : 1.0
// ============================================================================
module banked_register_file
    import banked_register_file_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int RD_PORTS = 3,
    parameter int BANKED   = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    banked_register_file_if.slave bus
);

    localparam int   NUM_ENTRIES = (BANKED != 0) ? NUM_PHYS_BANKED : NUM_PHYS_FLAT;
    localparam logic C_BANKED    = (BANKED != 0);

    logic [DATA_W-1:0] r_regs [NUM_ENTRIES];

    phys_idx_t w_wa_idx;
    phys_idx_t w_wb_idx;
    phys_idx_t w_lr_idx;
    phys_idx_t w_lock_idx;
    logic      w_wa_valid;
    logic      w_wb_valid;
    logic      w_wa_pc;
    logic      w_wb_pc;
    logic      w_collide;
    logic      w_wb_store;
    logic      w_link_store;

    logic [PHYS_W*RD_PORTS-1:0] w_rd_idx;
    logic [RD_PORTS-1:0]        w_rd_pc;
    logic [RD_PORTS-1:0]        w_busy;

    assign w_wa_idx   = phys_map(bus.mode, bus.wa_addr, C_BANKED);
    assign w_wb_idx   = phys_map(bus.mode, bus.wb_addr, C_BANKED);
    assign w_lr_idx   = phys_map(bus.mode, LR_ADDR, C_BANKED);
    assign w_lock_idx = phys_map(bus.mode, bus.lock_addr, C_BANKED);

    assign w_wa_pc    = bus.wa_en && (bus.wa_addr == PC_ADDR);
    assign w_wb_pc    = bus.wb_en && (bus.wb_addr == PC_ADDR);
    assign w_wa_valid = bus.wa_en && (bus.wa_addr != PC_ADDR);
    assign w_wb_valid = bus.wb_en && (bus.wb_addr != PC_ADDR);

    // Arbitration: A beats B, and either port beats the link write to LR.
    assign w_collide    = w_wa_valid && w_wb_valid && (w_wa_idx == w_wb_idx);
    assign w_wb_store   = w_wb_valid && !w_collide;
    assign w_link_store = bus.link &&
                          !(w_wa_valid && (w_wa_idx == w_lr_idx)) &&
                          !(w_wb_valid && (w_wb_idx == w_lr_idx));

    assign bus.wr_collide = w_collide;
    assign bus.pc_write   = w_wa_pc || w_wb_pc;
    assign bus.pc_data    = w_wa_pc ? bus.wa_data :
                            w_wb_pc ? bus.wb_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                r_regs[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (w_wa_valid && (w_wa_idx == phys_idx_t'(j))) begin
                    r_regs[j] <= bus.wa_data;
                end else if (w_wb_store && (w_wb_idx == phys_idx_t'(j))) begin
                    r_regs[j] <= bus.wb_data;
                end else if (w_link_store && (w_lr_idx == phys_idx_t'(j))) begin
                    r_regs[j] <= bus.pc_content;
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
            phys_idx_t         w_idx;
            logic              w_is_pc;
            logic [DATA_W-1:0] w_stored;
            logic [DATA_W-1:0] w_val;

            assign w_idx   = phys_map(bus.mode, bus.rd_addr[4*i +: 4], C_BANKED);
            assign w_is_pc = (bus.rd_addr[4*i +: 4] == PC_ADDR);

            assign w_rd_idx[PHYS_W*i +: PHYS_W] = w_idx;
            assign w_rd_pc[i]                   = w_is_pc;

            always_comb begin
                w_stored = '0;
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    if (w_idx == phys_idx_t'(j)) begin
                        w_stored = r_regs[j];
                    end
                end
            end

            // Bypass order mirrors write priority; reset suppresses bypass too.
            always_comb begin
                w_val = w_stored;
                if (w_is_pc) begin
                    w_val = bus.pc_content;
                end else if (!rst_n) begin
                    w_val = '0;
                end else if (w_wa_valid && (w_wa_idx == w_idx)) begin
                    w_val = bus.wa_data;
                end else if (w_wb_valid && (w_wb_idx == w_idx)) begin
                    w_val = bus.wb_data;
                end else if (bus.link && (w_lr_idx == w_idx)) begin
                    w_val = bus.pc_content;
                end
            end

            assign bus.rd_data[DATA_W*i +: DATA_W] = w_val;
        end
    endgenerate

    reg_lock_table #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .RD_PORTS    (RD_PORTS)
    ) u_lock_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_set_en  (bus.lock_en && (bus.lock_addr != PC_ADDR)),
        .i_set_idx (w_lock_idx),
        .i_clr_en  (w_wb_valid),
        .i_clr_idx (w_wb_idx),
        .i_rd_idx  (w_rd_idx),
        .i_rd_pc   (w_rd_pc),
        .o_busy    (w_busy)
    );

    assign bus.rd_busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_banked_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_banked_register_file
// Description : Directed and random checks of banked and flat register files
//               against an architectural (mode, register) reference model.
// Revision    : 1.0
// ============================================================================
module tb_banked_register_file;

    localparam int DW = 32;
    localparam int NP = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    banked_register_file_if #(.DATA_W(DW), .RD_PORTS(NP)) bus_b ();
    banked_register_file_if #(.DATA_W(DW), .RD_PORTS(NP)) bus_f ();

    banked_register_file #(.DATA_W(DW), .RD_PORTS(NP), .BANKED(1)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    banked_register_file #(.DATA_W(DW), .RD_PORTS(NP), .BANKED(0)) u_dut_f (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_f)
    );

    // Stimulus shared by both instances
    logic          t_rst;
    logic [1:0]    t_mode;
    logic [3:0]    t_ra [NP];
    logic [DW-1:0] t_pc;
    logic          t_wa_en, t_wb_en, t_link, t_lock_en;
    logic [3:0]    t_wa_addr, t_wb_addr, t_lock_addr;
    logic [DW-1:0] t_wa_data, t_wb_data;

    // Reference: [variant 0=flat 1=banked][bank USR/IRQ/SVC][arch reg 0..14]
    logic [DW-1:0] m_reg [2][3][15];
    bit            m_lk  [2][3][15];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int bank_of(input logic [1:0] m, input logic [3:0] a, input int v);
        if (v == 0 || a < 4'd13) return 0;
        if (m == 2'b01) return 1;
        if (m == 2'b10) return 2;
        return 0;
    endfunction

    task automatic clear_model();
        for (int v = 0; v < 2; v++)
            for (int k = 0; k < 3; k++)
                for (int a = 0; a < 15; a++) begin
                    m_reg[v][k][a] = '0;
                    m_lk[v][k][a]  = 1'b0;
                end
    endtask

    task automatic idle();
        t_wa_en = 0; t_wb_en = 0; t_link = 0; t_lock_en = 0;
        t_wa_addr = 0; t_wb_addr = 0; t_lock_addr = 0;
        t_wa_data = 0; t_wb_data = 0;
        for (int p = 0; p < NP; p++) t_ra[p] = 4'd0;
    endtask

    task automatic apply();
        rst_n = t_rst;
        bus_b.mode = t_mode; bus_f.mode = t_mode;
        bus_b.pc_content = t_pc; bus_f.pc_content = t_pc;
        bus_b.wa_en = t_wa_en; bus_f.wa_en = t_wa_en;
        bus_b.wa_addr = t_wa_addr; bus_f.wa_addr = t_wa_addr;
        bus_b.wa_data = t_wa_data; bus_f.wa_data = t_wa_data;
        bus_b.wb_en = t_wb_en; bus_f.wb_en = t_wb_en;
        bus_b.wb_addr = t_wb_addr; bus_f.wb_addr = t_wb_addr;
        bus_b.wb_data = t_wb_data; bus_f.wb_data = t_wb_data;
        bus_b.link = t_link; bus_f.link = t_link;
        bus_b.lock_en = t_lock_en; bus_f.lock_en = t_lock_en;
        bus_b.lock_addr = t_lock_addr; bus_f.lock_addr = t_lock_addr;
        for (int p = 0; p < NP; p++) begin
            bus_b.rd_addr[4*p +: 4] = t_ra[p];
            bus_f.rd_addr[4*p +: 4] = t_ra[p];
        end
    endtask

    // All accesses in one cycle share the mode, so equal address means same register.
    task automatic check_outputs();
        logic [DW-1:0] exp_d, act_d, exp_pcd;
        logic          exp_bz, act_bz, exp_col, exp_pcw;
        logic [3:0]    a;
        int            k;
        exp_col = t_wa_en && t_wb_en && (t_wa_addr == t_wb_addr) && (t_wa_addr != 4'd15);
        exp_pcw = (t_wa_en && t_wa_addr == 4'd15) || (t_wb_en && t_wb_addr == 4'd15);
        exp_pcd = (t_wa_en && t_wa_addr == 4'd15) ? t_wa_data :
                  (t_wb_en && t_wb_addr == 4'd15) ? t_wb_data : '0;
        for (int v = 0; v < 2; v++) begin
            for (int p = 0; p < NP; p++) begin
                a = t_ra[p];
                exp_bz = 1'b0;
                if (a == 4'd15) begin
                    exp_d = t_pc;
                end else if (!t_rst) begin
                    exp_d = '0;
                end else begin
                    k = bank_of(t_mode, a, v);
                    exp_d = m_reg[v][k][a];
                    if (t_link && a == 4'd14) exp_d = t_pc;
                    if (t_wb_en && t_wb_addr == a) exp_d = t_wb_data;
                    if (t_wa_en && t_wa_addr == a) exp_d = t_wa_data;
                    exp_bz = m_lk[v][k][a] && !(t_wb_en && t_wb_addr == a);
                end
                act_d  = (v == 1) ? bus_b.rd_data[DW*p +: DW] : bus_f.rd_data[DW*p +: DW];
                act_bz = (v == 1) ? bus_b.rd_busy[p] : bus_f.rd_busy[p];
                check_eq($sformatf("v%0d_rd_data%0d", v, p), act_d, exp_d);
                check_eq($sformatf("v%0d_rd_busy%0d", v, p), DW'(act_bz), DW'(exp_bz));
            end
            check_eq($sformatf("v%0d_wr_collide", v),
                     DW'((v == 1) ? bus_b.wr_collide : bus_f.wr_collide), DW'(exp_col));
            check_eq($sformatf("v%0d_pc_write", v),
                     DW'((v == 1) ? bus_b.pc_write : bus_f.pc_write), DW'(exp_pcw));
            check_eq($sformatf("v%0d_pc_data", v),
                     (v == 1) ? bus_b.pc_data : bus_f.pc_data, exp_pcd);
        end
    endtask

    // Apply in reverse priority so higher-priority writers overwrite.
    task automatic commit();
        for (int v = 0; v < 2; v++) begin
            if (t_link)
                m_reg[v][bank_of(t_mode, 4'd14, v)][14] = t_pc;
            if (t_wb_en && t_wb_addr != 4'd15) begin
                m_reg[v][bank_of(t_mode, t_wb_addr, v)][t_wb_addr] = t_wb_data;
                m_lk[v][bank_of(t_mode, t_wb_addr, v)][t_wb_addr]  = 1'b0;
            end
            if (t_wa_en && t_wa_addr != 4'd15)
                m_reg[v][bank_of(t_mode, t_wa_addr, v)][t_wa_addr] = t_wa_data;
            if (t_lock_en && t_lock_addr != 4'd15)
                m_lk[v][bank_of(t_mode, t_lock_addr, v)][t_lock_addr] = 1'b1;
        end
    endtask

    task automatic drive();
        @(negedge clk);
        apply();
        if (!t_rst) clear_model();
        #1;
        check_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        if (t_rst) commit();
    endtask

    function automatic logic [3:0] rnd_addr();
        if ($urandom_range(0, 1) == 1) return 4'($urandom_range(12, 15));
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        clear_model();
        idle();
        t_rst = 1'b0; t_mode = 2'b00; t_pc = 32'h1000;
        apply();

        // Reset state
        drive(); tick();
        t_rst = 1'b1;

        // Basic write then read on all ports
        t_wa_en = 1; t_wa_addr = 4'd3; t_wa_data = 32'h11;
        drive(); tick();
        idle(); for (int p = 0; p < NP; p++) t_ra[p] = 4'd3;
        drive();
        for (int p = 0; p < NP; p++) begin
            check_eq($sformatf("r3_port%0d", p), bus_b.rd_data[DW*p +: DW], 32'h11);
            check_eq($sformatf("r3_busy%0d", p), DW'(bus_b.rd_busy[p]), 32'h0);
        end
        tick();

        // Dual-port collision
        idle(); t_wa_en = 1; t_wa_addr = 4'd5; t_wa_data = 32'hAA;
        t_wb_en = 1; t_wb_addr = 4'd5; t_wb_data = 32'hBB; t_ra[0] = 4'd5;
        drive();
        check_eq("collide_bypass", bus_b.rd_data[DW-1:0], 32'hAA);
        check_eq("collide_flag", DW'(bus_b.wr_collide), 32'h1);
        tick();
        idle(); t_ra[0] = 4'd5;
        drive(); check_eq("collide_stored", bus_b.rd_data[DW-1:0], 32'hAA); tick();

        // Banked R13
        idle(); t_mode = 2'b10; t_wa_en = 1; t_wa_addr = 4'd13; t_wa_data = 32'h100;
        drive(); tick();
        idle(); t_mode = 2'b00; t_ra[0] = 4'd13;
        drive();
        check_eq("usr_r13_banked", bus_b.rd_data[DW-1:0], 32'h0);
        check_eq("usr_r13_flat", bus_f.rd_data[DW-1:0], 32'h100);
        tick();
        t_mode = 2'b10;
        drive(); check_eq("svc_r13_banked", bus_b.rd_data[DW-1:0], 32'h100); tick();

        // Link write, then link dropped against port A
        idle(); t_mode = 2'b00; t_pc = 32'h2000; t_link = 1;
        drive(); tick();
        idle(); t_ra[1] = 4'd14;
        drive(); check_eq("link_r14", bus_b.rd_data[DW +: DW], 32'h2000); tick();
        idle(); t_pc = 32'h3000; t_link = 1; t_wa_en = 1; t_wa_addr = 4'd14; t_wa_data = 32'h5;
        drive(); tick();
        idle(); t_ra[1] = 4'd14;
        drive(); check_eq("link_dropped", bus_b.rd_data[DW +: DW], 32'h5); tick();

        // Lock scoreboard
        idle(); t_lock_en = 1; t_lock_addr = 4'd7;
        drive(); tick();
        idle(); t_ra[0] = 4'd7;
        drive(); check_eq("r7_busy", DW'(bus_b.rd_busy[0]), 32'h1); tick();
        t_wb_en = 1; t_wb_addr = 4'd7; t_wb_data = 32'h77;
        drive();
        check_eq("r7_wb_busy", DW'(bus_b.rd_busy[0]), 32'h0);
        check_eq("r7_wb_data", bus_b.rd_data[DW-1:0], 32'h77);
        tick();
        t_lock_en = 1; t_lock_addr = 4'd7;
        drive(); tick();
        idle(); t_ra[0] = 4'd7;
        drive(); check_eq("r7_set_wins", DW'(bus_b.rd_busy[0]), 32'h1); tick();

        // PC write via port B
        idle(); t_wb_en = 1; t_wb_addr = 4'd15; t_wb_data = 32'h400; t_ra[2] = 4'd15;
        drive();
        check_eq("pc_write", DW'(bus_b.pc_write), 32'h1);
        check_eq("pc_data", bus_b.pc_data, 32'h400);
        check_eq("pc_read", bus_b.rd_data[2*DW +: DW], t_pc);
        tick();

        // Random traffic with occasional asynchronous reset
        for (int c = 0; c < 600; c++) begin
            t_rst       = ($urandom_range(0, 49) != 0);
            t_mode      = 2'($urandom_range(0, 3));
            t_pc        = $urandom;
            t_wa_en     = ($urandom_range(0, 1) == 1);
            t_wa_addr   = rnd_addr();
            t_wa_data   = $urandom;
            t_wb_en     = ($urandom_range(0, 1) == 1);
            t_wb_addr   = rnd_addr();
            t_wb_data   = $urandom;
            t_link      = ($urandom_range(0, 3) == 0);
            t_lock_en   = ($urandom_range(0, 2) == 0);
            t_lock_addr = rnd_addr();
            for (int p = 0; p < NP; p++) t_ra[p] = rnd_addr();
            drive();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
